keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//   Scans a 4x4 active-low matrix keypad, debounces it and emits one key per press
//   as a 1-cycle key_valid pulse with key_value. It is the sole input sequencer for
//   the password-lock datapath: key_value/key_valid connect directly to the lock core.
//   Key codes: digits 0-9, A=confirm, B=lock, C=clear, D=modify, E=show, F=spare.
// PARAMETERS
//   SCAN_DIV        50000  clk cycles per scan tick (1 ms at 50 MHz); must be >= 4
//   DEBOUNCE_SCANS  20     consecutive identical tick samples to accept a press/release
// PORTS
//   clk        in   1  system clock, 50 MHz
//   rst_n      in   1  asynchronous active-low reset
//   col_in     in   4  keypad columns, active-low, pulled up; asynchronous to clk
//   row_out    out  4  keypad row drive, one-cold (exactly one bit low)
//   key_value  out  4  code of last accepted key; held until next accepted key
//   key_valid  out  1  1-clk pulse, one per accepted press
//   key_held   out  1  high while a debounced key is pressed (PRESSED/RELEASE phase)
// BEHAVIOUR
//   Reset: row_out=4'b1110, key_value=0, key_valid=0, key_held=0, FSM=SCAN,
//     tick divider=0, debounce count=0, sync FFs=4'b1111.
//   col_in is synchronised through 2 FFs (col_s); every decision uses col_s only.
//   Tick: divider counts 0..SCAN_DIV-1; tick=1 for one clk when it equals SCAN_DIV-1,
//     then wraps to 0. All FSM actions below occur only on tick cycles.
//   Keymap (row r = row_out bit r low, col c = col_s bit c low):
//     r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: F 0 E D  (c0..c3 left to right)
//   FSM:
//   SCAN: col_s==4'hF -> rotate row_out left (1110->1101->1011->0111->1110).
//     exactly one col low -> latch row/col, cnt=1, go DEBOUNCE; row_out frozen.
//     >=2 cols low -> go RELEASE, cnt=0, no pulse (invalid chord).
//   DEBOUNCE: col_s == latched pattern -> cnt++; when cnt reaches DEBOUNCE_SCANS:
//     key_value<=map(row,col), key_valid=1 on the next clk only, key_held=1, go PRESSED.
//     col_s differs (bounce or release) -> cnt=0, go SCAN, row_out unchanged.
//   PRESSED: col_s==4'hF -> cnt=1, go RELEASE; otherwise stay (no auto-repeat,
//     a changed pattern is ignored until full release).
//   RELEASE: col_s==4'hF -> cnt++; at DEBOUNCE_SCANS -> key_held=0, cnt=0, go SCAN
//     and advance row_out; any col low -> cnt=0, stay.
//   key_held also goes high on the invalid-chord RELEASE entry? No: stays 0 there.
//   Latency: press stable from tick k is accepted at tick k+DEBOUNCE_SCANS-1;
//     key_valid is high the cycle after that tick. Max 2 clk extra from sync.
//   Row settling: row_out changes the cycle after a tick; next sample is SCAN_DIV-1
//     cycles later (>= 3 clk incl. sync) -> no stale-column sampling.
//   key_valid is never high two consecutive cycles; at most one pulse per
//     press-release cycle.
//   Cross-row ghosting (keys in different rows) is not detected; first row scanned wins.
//   rst_n low at any time (incl. DEBOUNCE/PRESSED) -> immediate reset values, no pulse;
//     after release scanning restarts from row 0 even if a key is still held.
//   Counters saturate-free: cnt width = clog2(DEBOUNCE_SCANS+1); divider = clog2(SCAN_DIV).
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3, clk 20 ns)
//   1 Reset, col_in=F -> row_out 1110,1101,1011,0111,1110 changing every 4 clk;
//     key_valid=0, key_value=0, key_held=0 throughout.
//   2 Hold col_in=1101 only while row_out=1101, then steady -> row_out freezes at 1101,
//     exactly one key_valid pulse with key_value=5, key_held=1.
//   3 Key '8' (r2,c1) low for 2 ticks then high 1 tick -> no pulse; then steady low
//     3 ticks -> one pulse key_value=8.
//   4 Hold 'A' (r0,c3) 100 ticks -> single pulse 0xA; release with 1-tick re-bounce
//     -> no second pulse; clean release 3 ticks -> key_held=0, scanning resumes;
//     re-press -> second pulse 0xA.
//   5 col_in=1100 on row r1 -> no pulse, key_held=0; release 3 ticks -> scan resumes.
//   6 rst_n pulsed low while PRESSED with '0' held -> outputs at reset values at once;
//     after rst_n high, '0' still held -> fresh pulse key_value=0 when row r3 reached.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with debounce and one-pulse key output
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       col_meta_q, col_s_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       row_out_q, row_out_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_value_q, key_value_d;
  logic             key_valid_q, key_valid_d;
  logic             held_q, held_d;

  logic             tick;
  logic             one_low;
  logic [1:0]       one_low_idx;
  logic [1:0]       row_idx;
  logic [3:0]       latched_pat;
  logic [CNT_W-1:0] cnt_inc;

  // Code printed on the key at (row, col); row 3 carries the F/0/E/D oddity of the keypad layout.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hF;  4'hD: code = 4'h0;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick        = (div_q == DIV_LAST);
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign latched_pat = ~(4'b0001 << col_idx_q);

  // Identify a single pressed column in the synchronised sample.
  always_comb begin
    one_low     = 1'b1;
    one_low_idx = 2'd0;
    case (col_s_q)
      4'b1110: one_low_idx = 2'd0;
      4'b1101: one_low_idx = 2'd1;
      4'b1011: one_low_idx = 2'd2;
      4'b0111: one_low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Row being driven low; the row is frozen while a key is handled, so it doubles as the latched row.
  always_comb begin
    case (row_out_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
    end
  end

  // Scan tick divider: one tick every SCAN_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Scan/debounce next state; all decisions are taken on tick cycles only.
  always_comb begin
    state_d     = state_q;
    row_out_d   = row_out_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_valid_d = 1'b0;
    held_d      = held_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (col_s_q == 4'hF) begin
            row_out_d = {row_out_q[2:0], row_out_q[3]};
          end else if (one_low) begin
            col_idx_d = one_low_idx;
            cnt_d     = CNT_ONE;
            state_d   = ST_DEBOUNCE;
          end else begin
            // Chord in one row: wait for full release without reporting anything.
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s_q == latched_pat) begin
            if (cnt_inc == CNT_DONE) begin
              key_value_d = map_key(row_idx, col_idx_q);
              key_valid_d = 1'b1;
              held_d      = 1'b1;
              cnt_d       = '0;
              state_d     = ST_PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (col_s_q == 4'hF) begin
            cnt_d   = CNT_ONE;
            state_d = ST_RELEASE;
          end
        end
        default: begin
          if (col_s_q == 4'hF) begin
            if (cnt_inc == CNT_DONE) begin
              held_d    = 1'b0;
              cnt_d     = '0;
              row_out_d = {row_out_q[2:0], row_out_q[3]};
              state_d   = ST_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_out_q   <= 4'b1110;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_value_q <= 4'h0;
      key_valid_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_out_q   <= row_out_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      held_q      <= held_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_held  = held_q;

endmodule
